// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: job sequencer that drives the 4-byte dot-product MAC.
// Optional WAIT watchdog is compiled in when CONV_SEQ_TIMEOUT_EN is defined.
module conv_mac_sequencer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_in_base,
    input  logic [ADDR_WIDTH-1:0] cfg_k_base,
    input  logic [ADDR_WIDTH-1:0] cfg_out_base,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  produced,
    output logic                  mac_start,
    input  logic                  mac_done,
    output logic                  mac_clr,
    output logic [ADDR_WIDTH-1:0] mac_a_addr,
    output logic [ADDR_WIDTH-1:0] mac_k_addr,
    output logic [ADDR_WIDTH-1:0] mac_out_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_FINISH
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  produced_q, produced_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic                  mac_start_q, mac_start_d;
    logic                  mac_clr_q, mac_clr_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic [ADDR_WIDTH-1:0] k_addr_q, k_addr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [CNT_WIDTH-1:0]  produced_inc;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
`endif

    assign produced_inc = produced_q + 1'b1;

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        produced_d  = produced_q;
        count_d     = count_q;
        stride_d    = stride_q;
        mac_start_d = 1'b0;
        mac_clr_d   = 1'b0;
        a_addr_d    = a_addr_q;
        k_addr_d    = k_addr_q;
        out_addr_d  = out_addr_q;
`ifdef CONV_SEQ_TIMEOUT_EN
        wcnt_d      = wcnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    produced_d = '0;
                    if (cfg_count != '0) begin
                        count_d     = cfg_count;
                        stride_d    = cfg_stride;
                        a_addr_d    = cfg_in_base;
                        k_addr_d    = cfg_k_base;
                        out_addr_d  = cfg_out_base;
                        err_d       = 1'b0;
                        busy_d      = 1'b1;
                        mac_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
`ifdef CONV_SEQ_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    mac_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
`ifdef CONV_SEQ_TIMEOUT_EN
                else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d     = 1'b1;
                    mac_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            S_CLEAR: begin
                // err_q is only set here by a watchdog abort of this job.
                if (err_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    produced_d = produced_inc;
                    a_addr_d   = a_addr_q + stride_q;
                    out_addr_d = out_addr_q + 1'b1;
                    if (produced_inc == count_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        mac_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            produced_q  <= '0;
            count_q     <= '0;
            stride_q    <= '0;
            mac_start_q <= 1'b0;
            mac_clr_q   <= 1'b0;
            a_addr_q    <= '0;
            k_addr_q    <= '0;
            out_addr_q  <= '0;
`ifdef CONV_SEQ_TIMEOUT_EN
            wcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            produced_q  <= produced_d;
            count_q     <= count_d;
            stride_q    <= stride_d;
            mac_start_q <= mac_start_d;
            mac_clr_q   <= mac_clr_d;
            a_addr_q    <= a_addr_d;
            k_addr_q    <= k_addr_d;
            out_addr_q  <= out_addr_d;
`ifdef CONV_SEQ_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign produced     = produced_q;
    assign mac_start    = mac_start_q;
    assign mac_clr      = mac_clr_q;
    assign mac_a_addr   = a_addr_q;
    assign mac_k_addr   = k_addr_q;
    assign mac_out_addr = out_addr_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer: table-driven and randomized checks of the MAC job sequencer
// against a mock MAC and an arithmetic reference of the expected address sequence.
module tb_conv_mac_sequencer;

`ifdef CONV_SEQ_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] cfg_in_base = '0;
    logic [7:0] cfg_k_base = '0;
    logic [7:0] cfg_out_base = '0;
    logic [7:0] cfg_count = '0;
    logic [7:0] cfg_stride = '0;
    logic       busy, done, err, mac_start, mac_clr;
    logic       mac_done;
    logic [7:0] produced, mac_a_addr, mac_k_addr, mac_out_addr;

    conv_mac_sequencer #(
        .ADDR_WIDTH(8),
        .CNT_WIDTH(8),
        .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_in_base(cfg_in_base),
        .cfg_k_base(cfg_k_base),
        .cfg_out_base(cfg_out_base),
        .cfg_count(cfg_count),
        .cfg_stride(cfg_stride),
        .busy(busy),
        .done(done),
        .err(err),
        .produced(produced),
        .mac_start(mac_start),
        .mac_done(mac_done),
        .mac_clr(mac_clr),
        .mac_a_addr(mac_a_addr),
        .mac_k_addr(mac_k_addr),
        .mac_out_addr(mac_out_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Mock MAC: done rises mock_delay cycles after start, held until mac_clr.
    int   mock_delay = 4;
    bit   mock_never = 1'b0;
    int   mcnt;
    logic mrun;
    always @(posedge clk or posedge mac_clr or posedge rst) begin
        if (mac_clr || rst) begin
            mac_done <= 1'b0;
            mrun     <= 1'b0;
            mcnt     <= 0;
        end else if (mac_start) begin
            mrun <= 1'b1;
            mcnt <= 1;
        end else if (mrun && !mac_done) begin
            if (!mock_never && mcnt >= mock_delay) mac_done <= 1'b1;
            else mcnt <= mcnt + 1;
        end
    end

    // Monitor: records issued operations and counts strobes.
    logic [7:0] qa[$], qk[$], qo[$];
    int n_start, n_clr, n_done, n_busy, n_unstable, tcyc, start_cyc, clr_cyc;
    logic in_op;
    logic [7:0] cap_a, cap_k, cap_o;
    always @(negedge clk) begin
        tcyc++;
        if (!rst) begin
            if (mac_clr) begin
                n_clr++;
                clr_cyc = tcyc;
                in_op = 1'b0;
            end else if (mac_start) begin
                qa.push_back(mac_a_addr);
                qk.push_back(mac_k_addr);
                qo.push_back(mac_out_addr);
                cap_a = mac_a_addr;
                cap_k = mac_k_addr;
                cap_o = mac_out_addr;
                start_cyc = tcyc;
                n_start++;
                in_op = 1'b1;
            end else if (in_op) begin
                if (mac_a_addr != cap_a || mac_k_addr != cap_k || mac_out_addr != cap_o)
                    n_unstable++;
            end
            if (done) n_done++;
            if (busy) n_busy++;
        end
    end

    task automatic clear_mon();
        qa.delete();
        qk.delete();
        qo.delete();
        n_start = 0;
        n_clr = 0;
        n_done = 0;
        n_busy = 0;
        n_unstable = 0;
        in_op = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] in_b, input logic [7:0] k_b,
                           input logic [7:0] out_b, input logic [7:0] cnt,
                           input logic [7:0] stride, input int d, input bit disturb,
                           input string tag);
        int cyc;
        int bound;
        logic [7:0] ea, eo;
        mock_delay = d;
        clear_mon();
        cfg_in_base = in_b;
        cfg_k_base = k_b;
        cfg_out_base = out_b;
        cfg_count = cnt;
        cfg_stride = stride;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (disturb) begin
            repeat (3) @(negedge clk);
            cfg_in_base = 8'($urandom);
            cfg_k_base = 8'($urandom);
            cfg_out_base = 8'($urandom);
            cfg_count = 8'($urandom_range(1, 9));
            cfg_stride = 8'($urandom);
            cfg_start = 1'b1;
            repeat (3) @(negedge clk);
            cfg_start = 1'b0;
        end
        bound = int'(cnt) * (d + 3) + 10;
        cyc = 0;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done_seen"}, int'(done), 1);
        if (cnt == 0) chk({tag, " done_latency"}, cyc, 0);
        repeat (2) @(negedge clk);
        chk({tag, " produced"}, int'(produced), int'(cnt));
        chk({tag, " starts"}, n_start, int'(cnt));
        chk({tag, " clears"}, n_clr, int'(cnt));
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " busy_cycles"}, n_busy, int'(cnt) * (d + 3));
        chk({tag, " addr_stable"}, n_unstable, 0);
        chk({tag, " busy_end"}, int'(busy), 0);
        chk({tag, " err"}, int'(err), 0);
        for (int i = 0; i < int'(cnt) && i < qa.size(); i++) begin
            ea = 8'(int'(in_b) + i * int'(stride));
            eo = 8'(int'(out_b) + i);
            chk($sformatf("%s a_addr[%0d]", tag, i), int'(qa[i]), int'(ea));
            chk($sformatf("%s k_addr[%0d]", tag, i), int'(qk[i]), int'(k_b));
            chk($sformatf("%s out_addr[%0d]", tag, i), int'(qo[i]), int'(eo));
        end
    endtask

    typedef struct {
        logic [7:0] in_b, k_b, out_b, cnt, stride;
        logic [7:0] exp_a_last, exp_o_last;
        int         exp_starts;
    } vec_t;

    vec_t vt[4];

    initial begin
        int cyc;
        vt[0] = '{8'h10, 8'h80, 8'hC0, 8'd3, 8'd1, 8'h12, 8'hC2, 3};
        vt[1] = '{8'hFE, 8'h33, 8'hFF, 8'd3, 8'd2, 8'h02, 8'h01, 3};
        vt[2] = '{8'h40, 8'h07, 8'h20, 8'd0, 8'd5, 8'h00, 8'h00, 0};
        vt[3] = '{8'hF0, 8'h01, 8'hFE, 8'd4, 8'h10, 8'h20, 8'h01, 4};

        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset produced", int'(produced), 0);
        chk("reset mac_start", int'(mac_start), 0);
        chk("reset mac_clr", int'(mac_clr), 0);
        chk("reset addrs", int'({mac_a_addr, mac_k_addr, mac_out_addr}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_job(vt[i].in_b, vt[i].k_b, vt[i].out_b, vt[i].cnt, vt[i].stride,
                    4, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d starts_tbl", i), qa.size(), vt[i].exp_starts);
            if (qa.size() > 0) begin
                chk($sformatf("vec%0d a_last", i), int'(qa[$]), int'(vt[i].exp_a_last));
                chk($sformatf("vec%0d o_last", i), int'(qo[$]), int'(vt[i].exp_o_last));
            end
        end

        run_job(8'h21, 8'h55, 8'h90, 8'd3, 8'd4, 4, 1'b1, "restart_ignored");

        for (int r = 0; r < 20; r++) begin
            run_job(8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom_range(1, 6)), 8'($urandom),
                    int'($urandom_range(1, 6)), 1'b0, $sformatf("rand%0d", r));
        end

        clear_mon();
        mock_delay = 4;
        cfg_in_base = 8'h08;
        cfg_k_base = 8'h18;
        cfg_out_base = 8'h28;
        cfg_count = 8'd4;
        cfg_stride = 8'd3;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cyc = 0;
        while (n_start < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst second_issue_seen", n_start, 2);
        repeat (2) @(negedge clk);
        chk("rst pre busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst async busy", int'(busy), 0);
        chk("rst async produced", int'(produced), 0);
        chk("rst async mac_clr", int'(mac_clr), 0);
        chk("rst async addrs", int'({mac_a_addr, mac_k_addr, mac_out_addr}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst no_done", n_done, 0);
        run_job(8'h50, 8'h60, 8'h70, 8'd2, 8'd1, 5, 1'b0, "after_rst");

        clear_mon();
        mock_never = 1'b1;
        cfg_count = 8'd2;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout done", int'(done), 1);
        chk("timeout err", int'(err), 1);
        chk("timeout produced", int'(produced), 0);
        chk("timeout clr_delay", clr_cyc - start_cyc, TB_TO + 1);
        chk("timeout busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        chk("timeout err_sticky", int'(err), 1);
`else
        repeat (100) @(negedge clk);
        chk("no_timeout busy", int'(busy), 1);
        chk("no_timeout err", int'(err), 0);
        chk("no_timeout clears", n_clr, 0);
        chk("no_timeout done", n_done, 0);
`endif
        mock_never = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
